// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the decode of illegal size/alignment combinations.
package lsu_pkg;

  localparam int unsigned MEM_AW_DEFAULT = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_e;

  function automatic logic lsu_bad_access(input logic [1:0] size, input logic [1:0] off);
    case (size_e'(size))
      SZ_BYTE: lsu_bad_access = 1'b0;
      SZ_HALF: lsu_bad_access = off[0];
      SZ_WORD: lsu_bad_access = |off;
      default: lsu_bad_access = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response handshake plus the data-memory port of the
// load/store unit; slave is the unit's view, master the execute+memory view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_mux.sv
// Little-endian lane logic: extracts and extends a load lane, and merges
// store data into the surrounding word for read-modify-write.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = word_i[{off_i[1], 4'b0000} +: 16];
    load_o   = word_i;
    merge_o  = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      SZ_WORD: merge_o = wdata_i;
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one byte/half/word load or store per request, with
// read-modify-write for sub-word stores and a single response per request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_AW = MEM_AW_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);
  state_e              state_q, state_d;
  logic                we_q, uns_q, err_q;
  size_e               size_q;
  logic [MEM_AW+1:0]   addr_q;
  logic [31:0]         wdata_q, word_q, rdata_q;
  logic                req_err, accept;
  logic [31:0]         lane_word, lane_load, lane_merge;

  // The lane mux sees live memory data during RD (load extract) and the
  // captured word during WR (store merge).
  always_comb begin
    req_err   = lsu_bad_access(bus.req_size, bus.req_addr[1:0]) ||
                ((bus.req_addr >> (MEM_AW + 2)) != 32'd0);
    accept    = (state_q == ST_IDLE) && bus.req_valid;
    lane_word = (state_q == ST_RD) ? bus.mem_rdata : word_q;
  end

  lsu_lane_mux u_lane (
    .word_i     (lane_word),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (lane_load),
    .merge_o    (lane_merge)
  );

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = (state_q == ST_IDLE);
    bus.mem_read   = (state_q == ST_RD);
    bus.mem_write  = (state_q == ST_WR);
    bus.mem_addr   = 32'(addr_q[MEM_AW+1:2]);
    bus.mem_wdata  = lane_merge;
    bus.resp_valid = (state_q == ST_RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_err)                                         state_d = ST_RESP;
          else if (bus.req_we && size_e'(bus.req_size) == SZ_WORD) state_d = ST_WR;
          else                                                 state_d = ST_RD;
        end
      end
      ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        err_q   <= req_err;
        size_q  <= size_e'(bus.req_size);
        addr_q  <= bus.req_addr[MEM_AW+1:0];
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
      end
      if (state_q == ST_RD) begin
        if (we_q) word_q  <= bus.mem_rdata;
        else      rdata_q <= lane_load;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, a reset
// abort sequence and randomized traffic against an arithmetic memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.MEM_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [int unsigned];
  logic [31:0] refmem [int unsigned];
  logic        pre_en = 1'b0;
  int unsigned pre_key;
  logic [31:0] pre_data;
  int unsigned rd_cnt = 0, wr_cnt = 0, rv_cnt = 0, both_cnt = 0;
  logic [31:0] last_maddr = '0;

  int unsigned checks = 0, fails = 0;

  function automatic logic [31:0] peek(input int unsigned k);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  // Data memory: samples read/write requests on the falling edge.
  always @(negedge clk) begin
    if (pre_en) mem[pre_key] = pre_data;
    if (bus.mem_read) begin
      bus.mem_rdata <= peek(bus.mem_addr);
      rd_cnt++;
      last_maddr = bus.mem_addr;
    end
    if (bus.mem_write) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      wr_cnt++;
      last_maddr = bus.mem_addr;
    end
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if (bus.resp_valid) rv_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] d);
    @(posedge clk);
    pre_key  = byte_addr >> 2;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    #1 pre_en = 1'b0;
  endtask

  logic [31:0] r_rdata, r_maddr;
  logic        r_err, r_ready;
  int unsigned r_lat, r_nrd, r_nwr;

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int unsigned rd0, wr0;
    @(negedge clk);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    r_lat = 1;
    while (!bus.resp_valid && r_lat < 10) begin
      @(posedge clk);
      #1 r_lat++;
    end
    r_rdata = bus.resp_rdata;
    r_err   = bus.resp_err;
    r_ready = bus.req_ready;
    r_nrd   = rd_cnt - rd0;
    r_nwr   = wr_cnt - wr0;
    r_maddr = last_maddr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    logic [1:0]  off;
    off = a[1:0];
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    logic [1:0]  off;
    off  = a[1:0];
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    return (w & ~(mask << (8 * off))) | ((d & mask) << (8 * off));
  endfunction

  typedef struct {
    logic        pre_en;
    logic [31:0] pre_addr;
    logic [31:0] pre_data;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_lat;
    int unsigned exp_nrd;
    int unsigned exp_nwr;
    logic [31:0] exp_maddr;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 32'h100,   32'h0,        1'b1, 2'd2, 1'b0, 32'h100,    32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'h40,   32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h0,     32'h0,        1'b0, 2'd2, 1'b0, 32'h100,    32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h40,   32'h0};
    vecs[2]  = '{1'b1, 32'h100,   32'h11223344, 1'b0, 2'd0, 1'b0, 32'h103,    32'h0,        32'h00000011, 1'b0, 2, 1, 0, 32'h40,   32'h0};
    vecs[3]  = '{1'b0, 32'h0,     32'h0,        1'b0, 2'd0, 1'b0, 32'h100,    32'h0,        32'h00000044, 1'b0, 2, 1, 0, 32'h40,   32'h0};
    vecs[4]  = '{1'b1, 32'h100,   32'h80FF0000, 1'b0, 2'd1, 1'b0, 32'h102,    32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h40,   32'h0};
    vecs[5]  = '{1'b0, 32'h0,     32'h0,        1'b0, 2'd1, 1'b1, 32'h102,    32'h0,        32'h000080FF, 1'b0, 2, 1, 0, 32'h40,   32'h0};
    vecs[6]  = '{1'b1, 32'h100,   32'h11223344, 1'b1, 2'd0, 1'b0, 32'h101,    32'h000000AA, 32'h0,        1'b0, 3, 1, 1, 32'h40,   32'h1122AA44};
    vecs[7]  = '{1'b0, 32'h0,     32'h0,        1'b0, 2'd1, 1'b0, 32'h101,    32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,    32'h0};
    vecs[8]  = '{1'b0, 32'h0,     32'h0,        1'b0, 2'd2, 1'b0, 32'h102,    32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,    32'h0};
    vecs[9]  = '{1'b0, 32'h0,     32'h0,        1'b0, 2'd3, 1'b0, 32'h100,    32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,    32'h0};
    vecs[10] = '{1'b0, 32'h0,     32'h0,        1'b0, 2'd2, 1'b0, 32'h40000,  32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,    32'h0};
    vecs[11] = '{1'b1, 32'h100,   32'h00008000, 1'b0, 2'd0, 1'b0, 32'h101,    32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h40,   32'h0};
    vecs[12] = '{1'b1, 32'h100,   32'h11223344, 1'b1, 2'd1, 1'b0, 32'h102,    32'h1234BEEF, 32'h0,        1'b0, 3, 1, 1, 32'h40,   32'hBEEF3344};
    vecs[13] = '{1'b0, 32'h0,     32'h0,        1'b1, 2'd2, 1'b0, 32'h101,    32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0, 32'h0,    32'hBEEF3344};
    vecs[14] = '{1'b0, 32'h0,     32'h0,        1'b1, 2'd2, 1'b0, 32'h3FFFC,  32'hCAFEF00D, 32'h0,        1'b0, 2, 0, 1, 32'hFFFF, 32'hCAFEF00D};
    vecs[15] = '{1'b1, 32'h3FFFC, 32'h0,        1'b1, 2'd0, 1'b0, 32'h3FFFF,  32'h1234565A, 32'h0,        1'b0, 3, 1, 1, 32'hFFFF, 32'h5A000000};

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    rst_n            = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err",   32'(bus.resp_err), 32'd0);
    chk("rst_mem_rw",     32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk("rst_req_ready",  32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].pre_en) preload(vecs[i].pre_addr, vecs[i].pre_data);
      issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_rdata", i), r_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i),   32'(r_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_lat", i),   r_lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_nrd", i),   r_nrd, vecs[i].exp_nrd);
      chk($sformatf("v%0d_nwr", i),   r_nwr, vecs[i].exp_nwr);
      chk($sformatf("v%0d_ready_busy", i), 32'(r_ready), 32'd0);
      if (vecs[i].exp_nrd + vecs[i].exp_nwr > 0)
        chk($sformatf("v%0d_maddr", i), r_maddr, vecs[i].exp_maddr);
      if (vecs[i].we)
        chk($sformatf("v%0d_memword", i), peek((vecs[i].addr >> 2) & 32'hFFFF), vecs[i].exp_word);
    end

    // Reset during the RD cycle of a byte store: no write, no response.
    begin
      int unsigned wr0, rv0;
      preload(32'h300, 32'h11223344);
      @(negedge clk);
      wr0 = wr_cnt;
      rv0 = rv_cnt;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd0;
      bus.req_addr  = 32'h301;
      bus.req_wdata = 32'hAA;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      chk("abort_in_rd", 32'(bus.mem_read), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_read_drop", 32'(bus.mem_read), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_write", wr_cnt - wr0, 32'd0);
      chk("abort_no_resp",  rv_cnt - rv0, 32'd0);
      chk("abort_memword",  peek(32'h300 >> 2), 32'h11223344);
      chk("abort_ready",    32'(bus.req_ready), 32'd1);
    end

    // Randomized traffic against the reference model.
    for (int w = 0; w < 16; w++) begin
      logic [31:0] d;
      d = $urandom;
      refmem[32'h80 + w] = d;
      preload(32'h200 + 4 * w, d);
    end
    for (int n = 0; n < 200; n++) begin
      logic        we, uns, e;
      logic [1:0]  sz;
      logic [31:0] a, wd, er;
      int unsigned el;
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = 2'($urandom);
      wd  = $urandom;
      a   = 32'h200 + $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(18, 31));
      e = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
          (a >= 32'h40000);
      el = e ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3));
      er = (e || we) ? 32'h0 : ref_load(refmem[a >> 2], a, sz, uns);
      if (!e && we) refmem[a >> 2] = ref_store(refmem[a >> 2], a, sz, wd);
      issue(we, sz, uns, a, wd);
      chk($sformatf("r%0d_rdata", n), r_rdata, er);
      chk($sformatf("r%0d_err", n),   32'(r_err), 32'(e));
      chk($sformatf("r%0d_lat", n),   r_lat, el);
      if (we && !e) chk($sformatf("r%0d_memword", n), peek(a >> 2), refmem[a >> 2]);
    end

    chk("never_read_and_write", both_cnt, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
